// File: rtl/izigzag_stream_dbuf.sv
// Inverse-zigzag reorder stage with two ping-pong coefficient banks.
// One bank fills from the zigzag-ordered input while the other drains
// row-by-row across NCH output channels. Supports raster bypass, a
// transposed read order and zero-padding of a partial block at end-of-stream.
module izigzag_stream_dbuf #(
  parameter int W   = 16,
  parameter int NCH = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [1:0]         mode,
  input  logic [W-1:0]       ruS_d,
  input  logic               ruS_e,
  input  logic               ruS_v,
  output logic               ruS_b,
  output logic [NCH*W-1:0]   ch_d,
  output logic [NCH-1:0]     ch_e,
  output logic [NCH-1:0]     ch_v,
  input  logic [NCH-1:0]     ch_b
);
  localparam int BPR = 8 / NCH;                 // beats per 8-wide row
  localparam int LB  = $clog2(BPR);
  localparam logic [5:0] LASTB = 6'(64 / NCH - 1);

  // zigzag position k -> natural index, entry k at [(63-k)*6 +: 6]
  localparam logic [383:0] ZZT = {
    6'd0, 6'd1, 6'd8, 6'd16,6'd9, 6'd2, 6'd3, 6'd10,6'd17,6'd24,6'd32,6'd25,6'd18,6'd11,6'd4, 6'd5,
    6'd12,6'd19,6'd26,6'd33,6'd40,6'd48,6'd41,6'd34,6'd27,6'd20,6'd13,6'd6, 6'd7, 6'd14,6'd21,6'd28,
    6'd35,6'd42,6'd49,6'd56,6'd57,6'd50,6'd43,6'd36,6'd29,6'd22,6'd15,6'd23,6'd30,6'd37,6'd44,6'd51,
    6'd58,6'd59,6'd52,6'd45,6'd38,6'd31,6'd39,6'd46,6'd53,6'd60,6'd61,6'd54,6'd47,6'd55,6'd62,6'd63};

  typedef enum logic [1:0] {W_FILL, W_WAIT, W_PAD, W_EOS} wState_t;
  typedef enum logic [1:0] {R_IDLE, R_DRAIN, R_EOS} rState_t;

  wState_t wState, wNext;
  rState_t rState, rNext;

  logic [1:0][63:0][W-1:0] mem;
  logic [1:0]              full;
  logic [1:0][1:0]         bMode;
  logic                    wb, rb, live, eosPend;
  logic [5:0]              k, beat;
  logic [1:0]              wrMode;
  logic [5:0]              wAddr;
  logic                    acc, memWe, fillDone, otherFree, fire, rdLast, eosDone;
  logic [W-1:0]            memWd;
  logic [NCH-1:0][W-1:0]   lane;

  assign ruS_b     = !(live && wState == W_FILL);
  assign acc       = ruS_v && !ruS_b;
  assign memWe     = (wState == W_FILL && acc && !ruS_e) || wState == W_PAD;
  assign memWd     = (wState == W_PAD) ? '0 : ruS_d;
  assign wrMode    = (k == 6'd0) ? mode : bMode[wb];
  assign wAddr     = (wrMode == 2'd1) ? k : ZZT[(63 - int'(k))*6 +: 6];
  assign fillDone  = memWe && k == 6'd63;
  assign fire      = ~|ch_b;
  assign rdLast    = rState == R_DRAIN && fire && beat == LASTB;
  assign eosDone   = rState == R_EOS && fire;
  // the bank we would switch to is free now, or is being released this very cycle
  assign otherFree = !full[~wb] || (rdLast && rb == ~wb);

  // write-side next state
  always_comb begin
    wNext = wState;
    case (wState)
      W_FILL: if (acc) begin
        if (ruS_e)            wNext = (k == 6'd0) ? W_EOS : W_PAD;
        else if (k == 6'd63)  wNext = otherFree ? W_FILL : W_WAIT;
      end
      W_WAIT: if (!full[wb]) wNext = W_FILL;
      W_PAD:  if (k == 6'd63) wNext = W_EOS;
      W_EOS:  if (eosDone)    wNext = W_FILL;
      default: wNext = W_FILL;
    endcase
  end

  // write-side state, zigzag counter, bank pointer and pending EOS
  always_ff @(posedge clock) begin
    if (!reset) begin
      wState <= W_FILL; k <= '0; wb <= 1'b0; live <= 1'b0; eosPend <= 1'b0; bMode <= '0;
    end else begin
      live   <= 1'b1;
      wState <= wNext;
      if (wState == W_FILL && acc && !ruS_e && k == 6'd0) bMode[wb] <= mode;
      if (memWe) k <= k + 6'd1;
      if (fillDone) wb <= ~wb;
      if ((wState == W_PAD && k == 6'd63) || (wState == W_FILL && acc && ruS_e && k == 6'd0))
        eosPend <= 1'b1;
      else if (eosDone)
        eosPend <= 1'b0;
    end
  end

  // coefficient storage; contents are don't-care until the bank is marked full
  always_ff @(posedge clock) begin
    if (memWe) mem[wb][wAddr] <= memWd;
  end

  // bank full flags: set by the filler, cleared by the last drained beat
  always_ff @(posedge clock) begin
    if (!reset) full <= '0;
    else begin
      if (fillDone) full[wb] <= 1'b1;
      if (rdLast)   full[rb] <= 1'b0;
    end
  end

  // read-side next state; a bank completing this cycle starts draining immediately
  always_comb begin
    rNext = rState;
    case (rState)
      R_IDLE:
        if (full[rb] || (fillDone && wb == rb)) rNext = R_DRAIN;
        else if (eosPend)                       rNext = R_EOS;
      R_DRAIN:
        if (rdLast) rNext = (full[~rb] || (fillDone && wb == ~rb)) ? R_DRAIN : R_IDLE;
      R_EOS:
        if (fire) rNext = R_IDLE;
      default: rNext = R_IDLE;
    endcase
  end

  // read-side state, beat counter and read bank pointer
  always_ff @(posedge clock) begin
    if (!reset) begin
      rState <= R_IDLE; beat <= '0; rb <= 1'b0;
    end else begin
      rState <= rNext;
      if (rState == R_DRAIN && fire) beat <= rdLast ? 6'd0 : beat + 6'd1;
      if (rdLast) rb <= ~rb;
    end
  end

  // per-channel read address: row/col from beat, swapped for transposed mode
  for (genvar c = 0; c < NCH; c++) begin : g_lane
    logic [2:0] rowIdx, colIdx;
    assign rowIdx  = 3'(beat >> LB);
    assign colIdx  = 3'((int'(beat) & (BPR - 1)) * NCH + c);
    assign lane[c] = (rState != R_DRAIN) ? '0 :
                     (bMode[rb] == 2'd2) ? mem[rb][{colIdx, rowIdx}] : mem[rb][{rowIdx, colIdx}];
  end

  assign ch_d = lane;
  assign ch_v = {NCH{rState != R_IDLE}};
  assign ch_e = {NCH{rState == R_EOS}};
endmodule

// File: tb/tb_izigzag_stream_dbuf.sv
// Scoreboard bench for izigzag_stream_dbuf: an NCH=8 and an NCH=2 instance.
module tb_izigzag_stream_dbuf;
  localparam int W = 16;

  logic clock = 0, reset = 0;
  always #5 clock = ~clock;
  logic [1:0] mode = 0;

  logic [W-1:0] d8 = 0; logic e8 = 0, v8 = 0, b8;
  logic [8*W-1:0] chd8; logic [7:0] che8, chv8, chb8 = 0;
  logic [W-1:0] d2 = 0; logic e2 = 0, v2 = 0, b2;
  logic [2*W-1:0] chd2; logic [1:0] che2, chv2, chb2 = 0;

  izigzag_stream_dbuf #(.W(W), .NCH(8)) dut8 (
    .clock(clock), .reset(reset), .mode(mode), .ruS_d(d8), .ruS_e(e8), .ruS_v(v8), .ruS_b(b8),
    .ch_d(chd8), .ch_e(che8), .ch_v(chv8), .ch_b(chb8));
  izigzag_stream_dbuf #(.W(W), .NCH(2)) dut2 (
    .clock(clock), .reset(reset), .mode(mode), .ruS_d(d2), .ruS_e(e2), .ruS_v(v2), .ruS_b(b2),
    .ch_d(chd2), .ch_e(che2), .ch_v(chv2), .ch_b(chb2));

  typedef struct { logic [8*W-1:0] d; logic e; } exp8_t;
  typedef struct { logic [2*W-1:0] d; logic e; } exp2_t;
  exp8_t q8[$]; exp2_t q2[$];
  logic [8*W-1:0] cap8[$]; logic [2*W-1:0] cap2[$];
  exp8_t x8; exp2_t x2;
  int vecs = 0, errs = 0, cyc = 0;

  int ZZ[64] = '{0,1,8,16,9,2,3,10,17,24,32,25,18,11,4,5,12,19,26,33,40,48,41,34,27,20,13,6,7,14,21,28,
                 35,42,49,56,57,50,43,36,29,22,15,23,30,37,44,51,58,59,52,45,38,31,39,46,53,60,61,54,47,55,62,63};

  always @(posedge clock) cyc <= cyc + 1;

  // monitor for the 8-channel instance
  always @(negedge clock) if (reset && chv8[0] && chb8 == 0) begin
    vecs++;
    cap8.push_back(chd8);
    if (q8.size() == 0) begin
      errs++; $display("FAIL beat8 unexpected: got d=%h e=%b", chd8, che8);
    end else begin
      x8 = q8.pop_front();
      if (chd8 !== x8.d || che8 !== {8{x8.e}} || chv8 !== 8'hFF) begin
        errs++; $display("FAIL beat8: got d=%h e=%b v=%b, expected d=%h e=%b", chd8, che8, chv8, x8.d, x8.e);
      end
    end
  end

  // monitor for the 2-channel instance
  always @(negedge clock) if (reset && chv2[0] && chb2 == 0) begin
    vecs++;
    cap2.push_back(chd2);
    if (q2.size() == 0) begin
      errs++; $display("FAIL beat2 unexpected: got d=%h e=%b", chd2, che2);
    end else begin
      x2 = q2.pop_front();
      if (chd2 !== x2.d || che2 !== {2{x2.e}} || chv2 !== 2'b11) begin
        errs++; $display("FAIL beat2: got d=%h e=%b v=%b, expected d=%h e=%b", chd2, che2, chv2, x2.d, x2.e);
      end
    end
  end

  task automatic chk(input string nm, input logic [255:0] got, input logic [255:0] exp);
    vecs++;
    if (got !== exp) begin errs++; $display("FAIL %s: got %0h expected %0h", nm, got, exp); end
  endtask

  function automatic logic [8*W-1:0] p8(input int a0, a1, a2, a3, a4, a5, a6, a7);
    return {W'(a7), W'(a6), W'(a5), W'(a4), W'(a3), W'(a2), W'(a1), W'(a0)};
  endfunction
  function automatic logic [2*W-1:0] p2(input int a0, a1);
    return {W'(a1), W'(a0)};
  endfunction

  // expected natural-order block: token base+k at position k (zigzag unless mode 1), rest zero
  task automatic natBlk(input int base, input int n, input int m, output int nat[64]);
    for (int i = 0; i < 64; i++) nat[i] = 0;
    for (int i = 0; i < n; i++) if (m == 1) nat[i] = base + i; else nat[ZZ[i]] = base + i;
  endtask

  task automatic pushBlk8(input int base, input int n, input int m);
    int nat[64]; exp8_t x;
    natBlk(base, n, m, nat);
    for (int b = 0; b < 8; b++) begin
      for (int c = 0; c < 8; c++) x.d[c*W +: W] = W'(nat[(m == 2) ? c*8 + b : b*8 + c]);
      x.e = 0; q8.push_back(x);
    end
  endtask

  task automatic pushBlk2(input int base, input int m);
    int nat[64]; exp2_t x;
    natBlk(base, 64, m, nat);
    for (int b = 0; b < 32; b++) begin
      for (int c = 0; c < 2; c++) begin
        int row, col;
        row = b / 4; col = (b % 4) * 2 + c;
        x.d[c*W +: W] = W'(nat[(m == 2) ? col*8 + row : row*8 + col]);
      end
      x.e = 0; q2.push_back(x);
    end
  endtask

  task automatic pushEos8();
    exp8_t x; x.d = '0; x.e = 1; q8.push_back(x);
  endtask

  // inputs change 1 time unit after the rising edge
  task automatic send8(input int val, input logic e);
    int n = 0;
    d8 = W'(val); e8 = e; v8 = 1;
    while (b8 && n < 3000) begin @(posedge clock); #1; n++; end
    if (n >= 3000) begin vecs++; errs++; $display("FAIL send8 timeout: ruS_b stuck at %b, required 0", b8); end
    @(posedge clock); #1;
    v8 = 0; e8 = 0;
  endtask

  task automatic send2(input int val);
    int n = 0;
    d2 = W'(val); e2 = 0; v2 = 1;
    while (b2 && n < 3000) begin @(posedge clock); #1; n++; end
    if (n >= 3000) begin vecs++; errs++; $display("FAIL send2 timeout: ruS_b stuck at %b, required 0", b2); end
    @(posedge clock); #1;
    v2 = 0;
  endtask

  task automatic blk8(input int base, input int n, input int m, input logic eos);
    pushBlk8(base, n, m);
    if (eos) pushEos8();
    mode = 2'(m);
    for (int i = 0; i < n; i++) send8(base + i, 0);
    if (eos) send8(0, 1);
  endtask

  task automatic waitEmpty8(input string nm);
    int n = 0;
    while (q8.size() != 0 && n < 3000) begin @(posedge clock); #1; n++; end
    repeat (3) @(posedge clock); #1;
    chk(nm, q8.size(), 0);
  endtask

  task automatic waitEmpty2(input string nm);
    int n = 0;
    while (q2.size() != 0 && n < 3000) begin @(posedge clock); #1; n++; end
    repeat (3) @(posedge clock); #1;
    chk(nm, q2.size(), 0);
  endtask

  task automatic t1Checks(input string nm);
    chk({nm, " beats"}, cap8.size(), 8);
    chk({nm, " beat0"}, cap8[0], p8(0, 1, 5, 6, 14, 15, 27, 28));
    chk({nm, " beat1"}, cap8[1], p8(2, 4, 7, 13, 16, 26, 29, 42));
    chk({nm, " beat7"}, cap8[7], p8(35, 36, 48, 49, 57, 58, 62, 63));
  endtask

  logic [8*W-1:0] snap;
  int t0;

  initial begin
    // reset state
    repeat (3) @(posedge clock); #1;
    chk("rst ruS_b", b8, 1); chk("rst ch_v", chv8, 0); chk("rst ch_e", che8, 0);
    chk("rst ch_d", chd8, 0); chk("rst ruS_b nch2", b2, 1); chk("rst ch_v nch2", chv2, 0);
    reset = 1;
    @(posedge clock); #1;
    chk("ruS_b after reset", b8, 0);

    // T1: inverse zigzag, first beat one cycle after the 64th accept
    cap8.delete();
    pushBlk8(0, 64, 0);
    mode = 0;
    for (int i = 0; i < 63; i++) send8(i, 0);
    d8 = W'(63); v8 = 1; @(posedge clock); #1; v8 = 0;
    chk("T1 latency ch_v", chv8, 8'hFF);
    waitEmpty8("T1 drained");
    t1Checks("T1");

    // T2: raster bypass, then transposed
    cap8.delete();
    blk8(0, 64, 1, 0);
    blk8(0, 64, 2, 0);
    waitEmpty8("T2 drained");
    chk("T2 mode1 beat3", cap8[3], p8(24, 25, 26, 27, 28, 29, 30, 31));
    chk("T2 mode2 beat0", cap8[8], p8(0, 2, 3, 9, 10, 20, 21, 35));

    // T3a: three blocks back-to-back never stall the input
    t0 = cyc;
    blk8(100, 64, 0, 0); blk8(200, 64, 0, 0); blk8(300, 64, 0, 0);
    chk("T3 input cycles", cyc - t0, 192);
    waitEmpty8("T3a drained");

    // T3b: one channel backpressured for 100 cycles
    fork
      begin blk8(400, 64, 0, 0); blk8(500, 64, 0, 0); blk8(600, 64, 0, 0); end
      begin
        repeat (66) @(posedge clock); #1;
        chb8 = 8'h08;
        repeat (75) @(posedge clock); #1;
        chk("T3 ruS_b stalled", b8, 1);
        snap = chd8;
        repeat (10) @(posedge clock); #1;
        chk("T3 frozen ch_d", chd8, snap);
        chk("T3 frozen ch_v", chv8, 8'hFF);
        repeat (15) @(posedge clock); #1;
        chb8 = 0;
      end
    join
    waitEmpty8("T3b drained");

    // T4: two channels
    cap2.delete();
    pushBlk2(0, 0);
    mode = 0;
    for (int i = 0; i < 64; i++) send2(i);
    waitEmpty2("T4 drained");
    chk("T4 beats", cap2.size(), 32);
    chk("T4 beat0", cap2[0], p2(0, 1));
    chk("T4 beat1", cap2[1], p2(5, 6));
    chk("T4 beat4", cap2[4], p2(2, 4));

    // T5: partial block padded, then EOS; then EOS alone; then normal block resumes
    cap8.delete();
    blk8(0, 10, 0, 1);
    waitEmpty8("T5 pad drained");
    chk("T5 pad beats", cap8.size(), 9);
    chk("T5 pad beat0", cap8[0], p8(0, 1, 5, 6, 0, 0, 0, 0));
    chk("T5 pad beat1", cap8[1], p8(2, 4, 7, 0, 0, 0, 0, 0));
    chk("T5 eos ch_d", cap8[8], 0);
    cap8.delete();
    pushEos8(); send8(0, 1);
    waitEmpty8("T5 eos-only drained");
    chk("T5 eos-only beats", cap8.size(), 1);
    blk8(0, 64, 0, 0);
    waitEmpty8("T5 resume drained");

    // T6: reset during drain, then a fresh block
    pushBlk8(0, 64, 0);
    mode = 0;
    for (int i = 0; i < 64; i++) send8(i, 0);
    repeat (2) @(posedge clock); #1;
    reset = 0;
    @(posedge clock); #1;
    q8.delete();
    chk("T6 reset ch_v", chv8, 0);
    chk("T6 reset ruS_b", b8, 1);
    reset = 1;
    @(posedge clock); #1;
    cap8.delete();
    blk8(0, 64, 0, 0);
    waitEmpty8("T6 drained");
    t1Checks("T6");

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
